// File: rtl/mem_req_merge_unit.sv
// Merges imem and dmem request streams onto one shared 4B memory port and routes responses back.
// The request opaque field carries the source tag in bit 0. Each source has its own outstanding-request limit.
module mem_req_merge_unit #(
  parameter int unsigned p_max_outstanding = 4,
  parameter bit          p_reset_prio      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [76:0] imemreq_msg,
  input  logic        imemreq_val,
  output logic        imemreq_rdy,

  input  logic [76:0] dmemreq_msg,
  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,

  output logic [76:0] memreq_msg,
  output logic        memreq_val,
  input  logic        memreq_rdy,

  input  logic [44:0] memresp_msg,
  input  logic        memresp_val,
  output logic        memresp_rdy,

  output logic [44:0] imemresp_msg,
  output logic        imemresp_val,
  input  logic        imemresp_rdy,

  output logic [44:0] dmemresp_msg,
  output logic        dmemresp_val,
  input  logic        dmemresp_rdy,

  output logic        proto_err
);

  typedef enum logic {
    SRC_IMEM = 1'b0,
    SRC_DMEM = 1'b1
  } src_e;

  localparam int         ReqOpqLsb  = 66;
  localparam int         RespOpqLsb = 34;
  localparam logic [3:0] MaxOut     = 4'(p_max_outstanding);

  src_e       prio_q, prio_d;
  src_e       lockSrc_q, lockSrc_d;
  logic       lock_q, lock_d;
  logic [3:0] iCount_q, iCount_d;
  logic [3:0] dCount_q, dCount_d;
  logic       protoErr_q, protoErr_d;

  src_e       grant;
  logic       eligI, eligD;
  logic       reqFire, iReqFire, dReqFire;
  logic       respSel, iRespFire, dRespFire;
  logic [7:0] reqOpaque;

  function automatic logic [3:0] nextCount(input logic [3:0] cnt, input logic inc, input logic dec);
    if (inc && !dec) return cnt + 4'd1;
    if (dec && !inc && (cnt != 4'd0)) return cnt - 4'd1;
    return cnt;
  endfunction

  assign eligI = imemreq_val && (iCount_q < MaxOut);
  assign eligD = dmemreq_val && (dCount_q < MaxOut);

  // A stalled request keeps its grant so the request does not change while the memory is not ready
  always_comb begin
    grant = prio_q;
    if (lock_q) begin
      grant = lockSrc_q;
    end else if (eligI && !eligD) begin
      grant = SRC_IMEM;
    end else if (eligD && !eligI) begin
      grant = SRC_DMEM;
    end
  end

  always_comb begin
    memreq_msg  = (grant == SRC_DMEM) ? dmemreq_msg : imemreq_msg;
    reqOpaque   = memreq_msg[ReqOpqLsb +: 8];
    memreq_msg[ReqOpqLsb +: 8] = {reqOpaque[6:0], grant};
    memreq_val  = !reset && ((grant == SRC_DMEM) ? eligD : eligI);
    imemreq_rdy = !reset && (grant == SRC_IMEM) && eligI && memreq_rdy;
    dmemreq_rdy = !reset && (grant == SRC_DMEM) && eligD && memreq_rdy;
  end

  assign reqFire  = memreq_val && memreq_rdy;
  assign iReqFire = reqFire && (grant == SRC_IMEM);
  assign dReqFire = reqFire && (grant == SRC_DMEM);

  always_comb begin
    respSel      = memresp_msg[RespOpqLsb];
    imemresp_msg = memresp_msg;
    imemresp_msg[RespOpqLsb +: 8] = {1'b0, memresp_msg[RespOpqLsb+1 +: 7]};
    dmemresp_msg = imemresp_msg;
    imemresp_val = !reset && memresp_val && !respSel;
    dmemresp_val = !reset && memresp_val && respSel;
    memresp_rdy  = !reset && (respSel ? dmemresp_rdy : imemresp_rdy);
  end

  assign iRespFire = memresp_val && memresp_rdy && !respSel;
  assign dRespFire = memresp_val && memresp_rdy && respSel;

  // Responses are always delivered, even to a source with no outstanding requests; that case is only flagged
  always_comb begin
    lock_d     = lock_q;
    lockSrc_d  = lockSrc_q;
    prio_d     = prio_q;
    iCount_d   = nextCount(iCount_q, iReqFire, iRespFire);
    dCount_d   = nextCount(dCount_q, dReqFire, dRespFire);
    protoErr_d = protoErr_q
               || (iRespFire && (iCount_q == 4'd0))
               || (dRespFire && (dCount_q == 4'd0));
    if (reqFire) begin
      lock_d = 1'b0;
      prio_d = src_e'(~grant);
    end else if (memreq_val) begin
      lock_d    = 1'b1;
      lockSrc_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= src_e'(p_reset_prio);
      lockSrc_q  <= SRC_IMEM;
      lock_q     <= 1'b0;
      iCount_q   <= 4'd0;
      dCount_q   <= 4'd0;
      protoErr_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      lockSrc_q  <= lockSrc_d;
      lock_q     <= lock_d;
      iCount_q   <= iCount_d;
      dCount_q   <= dCount_d;
      protoErr_q <= protoErr_d;
    end
  end

  assign proto_err = protoErr_q;

endmodule

// File: tb/tb_mem_req_merge_unit.sv
// Testbench for mem_req_merge_unit: directed vectors, a transaction-level reference model
// compared on every negedge, and hand-computed literal checks.
module tb_mem_req_merge_unit;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [76:0] imemreq_msg = '0;
  logic        imemreq_val = 1'b0;
  logic        imemreq_rdy;
  logic [76:0] dmemreq_msg = '0;
  logic        dmemreq_val = 1'b0;
  logic        dmemreq_rdy;
  logic [76:0] memreq_msg;
  logic        memreq_val;
  logic        memreq_rdy = 1'b0;
  logic [44:0] memresp_msg = '0;
  logic        memresp_val = 1'b0;
  logic        memresp_rdy;
  logic [44:0] imemresp_msg;
  logic        imemresp_val;
  logic        imemresp_rdy = 1'b1;
  logic [44:0] dmemresp_msg;
  logic        dmemresp_val;
  logic        dmemresp_rdy = 1'b1;
  logic        proto_err;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: outstanding counts, round-robin owner, stall lock, sticky error
  int   iOut = 0, dOut = 0;
  logic prio = 1'b0, lockV = 1'b0, lockS = 1'b0, mErr = 1'b0;
  bit   modelValid = 1'b0;
  logic g, eI, eD, expVal, fire, sel, iRF, dRF, iInc, dInc;

  mem_req_merge_unit #(.p_max_outstanding(MAX), .p_reset_prio(1'b0)) dut (
    .clk(clk), .reset(reset),
    .imemreq_msg(imemreq_msg), .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .dmemreq_msg(dmemreq_msg), .dmemreq_val(dmemreq_val), .dmemreq_rdy(dmemreq_rdy),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .imemresp_msg(imemresp_msg), .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .dmemresp_msg(dmemresp_msg), .dmemresp_val(dmemresp_val), .dmemresp_rdy(dmemresp_rdy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [76:0] mkReq(input logic isD, input logic [7:0] opq);
    logic [31:0] addr, data;
    addr = 32'h0000_1000 + {24'd0, opq} + (isD ? 32'h0000_8000 : 32'h0);
    data = (isD ? 32'hB000_0000 : 32'hA000_0000) | {24'd0, opq};
    return {3'd0, opq, addr, 2'd0, data};
  endfunction

  function automatic logic [44:0] mkResp(input logic [7:0] opq, input logic [31:0] data);
    return {3'd1, opq, 2'd0, data};
  endfunction

  function automatic logic [76:0] tagReq(input logic [76:0] m, input logic s);
    logic [7:0] o;
    o = m[73:66];
    o = 8'((o << 1) | {7'd0, s});
    return {m[76:74], o, m[65:0]};
  endfunction

  function automatic logic [44:0] untag(input logic [44:0] r);
    logic [7:0] o;
    o = r[41:34];
    o = o / 8'd2;
    return {r[44:42], o, r[33:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [76:0] act, input logic [76:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] io, input logic dv, input logic [7:0] dop,
                               input logic mr, input logic rv, input logic [7:0] ro, input logic [31:0] rd);
    @(posedge clk);
    #1;
    imemreq_val = iv;
    imemreq_msg = mkReq(1'b0, io);
    dmemreq_val = dv;
    dmemreq_msg = mkReq(1'b1, dop);
    memreq_rdy  = mr;
    memresp_val = rv;
    memresp_msg = mkResp(ro, rd);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: outputs follow from the arbitration, credit and routing rules each cycle
  always @(negedge clk) begin
    if (reset) begin
      checkBit("rst_memreq_val", memreq_val, 1'b0);
      checkBit("rst_imemreq_rdy", imemreq_rdy, 1'b0);
      checkBit("rst_dmemreq_rdy", dmemreq_rdy, 1'b0);
      checkBit("rst_memresp_rdy", memresp_rdy, 1'b0);
      checkBit("rst_imemresp_val", imemresp_val, 1'b0);
      checkBit("rst_dmemresp_val", dmemresp_val, 1'b0);
      if (modelValid) checkBit("rst_proto_err", proto_err, mErr);
      prio = 1'b0; lockV = 1'b0; lockS = 1'b0; iOut = 0; dOut = 0; mErr = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      eI = imemreq_val && (iOut < MAX);
      eD = dmemreq_val && (dOut < MAX);
      if (lockV) g = lockS;
      else if (eI && eD) g = prio;
      else if (eI) g = 1'b0;
      else if (eD) g = 1'b1;
      else g = prio;
      expVal = g ? eD : eI;
      checkBit("memreq_val", memreq_val, expVal);
      if (expVal) checkOutput("memreq_msg", memreq_msg, tagReq(g ? dmemreq_msg : imemreq_msg, g));
      checkBit("imemreq_rdy", imemreq_rdy, memreq_rdy && expVal && !g);
      checkBit("dmemreq_rdy", dmemreq_rdy, memreq_rdy && expVal && g);
      sel = memresp_msg[34];
      checkBit("imemresp_val", imemresp_val, memresp_val && !sel);
      checkBit("dmemresp_val", dmemresp_val, memresp_val && sel);
      checkBit("memresp_rdy", memresp_rdy, sel ? dmemresp_rdy : imemresp_rdy);
      if (memresp_val && !sel) checkOutput("imemresp_msg", 77'(imemresp_msg), 77'(untag(memresp_msg)));
      if (memresp_val && sel) checkOutput("dmemresp_msg", 77'(dmemresp_msg), 77'(untag(memresp_msg)));
      checkBit("proto_err", proto_err, mErr);

      fire = expVal && memreq_rdy;
      iInc = fire && !g;
      dInc = fire && g;
      iRF  = memresp_val && !sel && imemresp_rdy;
      dRF  = memresp_val && sel && dmemresp_rdy;
      if (iRF && iOut == 0) mErr = 1'b1;
      if (dRF && dOut == 0) mErr = 1'b1;
      if (iInc && !iRF) iOut++;
      else if (iRF && !iInc && iOut > 0) iOut--;
      if (dInc && !dRF) dOut++;
      else if (dRF && !dInc && dOut > 0) dOut--;
      if (fire) begin
        lockV = 1'b0;
        prio  = ~g;
      end else if (expVal) begin
        lockV = 1'b1;
        lockS = g;
      end
    end
  end

  initial begin
    // Outputs forced low while reset is held, even with every input asserting
    imemreq_val = 1'b1; dmemreq_val = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b1;
    @(negedge clk);
    checkBit("lit_rst_memreq_val", memreq_val, 1'b0);
    checkBit("lit_rst_memresp_rdy", memresp_rdy, 1'b0);
    checkBit("lit_rst_proto_err", proto_err, 1'b0);

    // Alternating grants starting with imem
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("lit_alt_opaque", 77'(memreq_msg[73:66]), 77'((k % 2 == 0) ? 8'h00 : 8'h01));
      checkOutput("lit_alt_data", 77'(memreq_msg[31:0]), 77'((k % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000));
    end

    // Stall lock: dmem granted alone, imem appears during stall
    doReset();
    applyStimulus(1'b0, 8'h03, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkOutput("lit_stall_opq0", 77'(memreq_msg[73:66]), 77'(8'h0B));
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 8'h03, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      checkOutput("lit_stall_opq", 77'(memreq_msg[73:66]), 77'(8'h0B));
      checkBit("lit_stall_irdy", imemreq_rdy, 1'b0);
    end
    applyStimulus(1'b1, 8'h03, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkBit("lit_stall_dfire", dmemreq_rdy, 1'b1);
    applyStimulus(1'b1, 8'h03, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkBit("lit_after_ifire", imemreq_rdy, 1'b1);
    checkOutput("lit_after_opq", 77'(memreq_msg[73:66]), 77'(8'h06));

    // Credit limit on imem
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      checkBit("lit_credit_rdy", imemreq_rdy, 1'b1);
    end
    applyStimulus(1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
    checkOutput("model_icount_full", 77'(iOut), 77'(4));
    @(negedge clk);
    checkBit("lit_credit_block", imemreq_rdy, 1'b0);
    checkBit("lit_credit_val", memreq_val, 1'b0);
    applyStimulus(1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 32'h0000_0055);
    @(negedge clk);
    checkBit("lit_credit_still_block", imemreq_rdy, 1'b0);
    checkBit("lit_credit_resp_val", imemresp_val, 1'b1);
    applyStimulus(1'b1, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkBit("lit_credit_refire", imemreq_rdy, 1'b1);

    // Response demux to dmem with dmem not ready
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 32'hDEAD_BEEF);
    dmemresp_rdy = 1'b0;
    @(negedge clk);
    checkBit("lit_demux_dval", dmemresp_val, 1'b1);
    checkBit("lit_demux_ival", imemresp_val, 1'b0);
    checkOutput("lit_demux_opq", 77'(dmemresp_msg[41:34]), 77'(8'h00));
    checkOutput("lit_demux_data", 77'(dmemresp_msg[31:0]), 77'(32'hDEAD_BEEF));
    checkBit("lit_demux_rdy", memresp_rdy, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
    dmemresp_rdy = 1'b1;

    // Same-cycle request fire and response fire on imem
    doReset();
    repeat (2) applyStimulus(1'b1, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
    applyStimulus(1'b1, 8'h12, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 32'h0000_0077);
    @(negedge clk);
    checkBit("lit_same_req", imemreq_rdy, 1'b1);
    checkBit("lit_same_resp", memresp_rdy, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      if (k == 0) checkOutput("model_icount_same", 77'(iOut), 77'(2));
      @(negedge clk);
      checkBit("lit_same_remaining", imemreq_rdy, k < 2);
    end

    // Underflow: response to imem with nothing outstanding
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 32'h1234_5678);
    @(negedge clk);
    checkBit("lit_uf_val", imemresp_val, 1'b1);
    checkOutput("lit_uf_opq", 77'(imemresp_msg[41:34]), 77'(8'h02));
    checkBit("lit_uf_err_before", proto_err, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checkBit("lit_uf_err", proto_err, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 8'h30, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      checkBit("lit_uf_count_zero", imemreq_rdy, k < 4);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    checkBit("lit_uf_err_hold", proto_err, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    checkBit("lit_uf_err_clear", proto_err, 1'b0);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
